// File: rtl/ras_checkpoint_q.sv
// ras_checkpoint_q: tagged RAS idx/cnt checkpoints, restored on mispredict into a registered RAS update.
module ras_checkpoint_q #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 3,
  parameter int RAS_ENTRIES = 2**IDX_W,
  parameter int CNT_W = $clog2(RAS_ENTRIES + 1),
  localparam int TW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq_valid,
  input  logic [IDX_W-1:0] enq_ras_idx,
  input  logic [CNT_W-1:0] enq_ras_cnt,
  output logic             enq_ready,
  output logic [TW-1:0]    enq_tag,
  input  logic             commit_valid,
  input  logic             restore_valid,
  input  logic [TW-1:0]    restore_tag,
  input  logic [1:0]       restore_op,
  output logic             update_valid,
  output logic [IDX_W-1:0] update_ras_idx,
  output logic [CNT_W-1:0] update_ras_cnt
);
  logic [IDX_W-1:0] idx_mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_mem_q [DEPTH];
  logic [TW:0]      head_q, head_d, tail_q, tail_d, count;
  logic [TW-1:0]    off;
  logic             empty, full, live, enq_fire, commit_fire;
  logic [IDX_W-1:0] s_idx, r_idx;
  logic [CNT_W-1:0] s_cnt, c_pop, r_cnt;
  always_comb begin
    count = tail_q - head_q;
    empty = count == '0;
    full = count[TW];
    enq_ready = !full && !restore_valid;
    enq_tag = tail_q[TW-1:0];
    enq_fire = enq_valid && enq_ready;
    commit_fire = commit_valid && !empty;
    off = restore_tag - head_q[TW-1:0];
    live = restore_valid && ({1'b0, off} < count);
    s_idx = idx_mem_q[restore_tag];
    s_cnt = cnt_mem_q[restore_tag];
    // pop is applied before push so link+ret leaves idx unchanged and cnt saturates correctly
    r_idx = s_idx + IDX_W'(restore_op[0]) - IDX_W'(restore_op[1]);
    c_pop = (restore_op[1] && s_cnt != '0) ? s_cnt - CNT_W'(1) : s_cnt;
    r_cnt = (restore_op[0] && c_pop != CNT_W'(RAS_ENTRIES)) ? c_pop + CNT_W'(1) : c_pop;
    head_d = head_q + {{TW{1'b0}}, commit_fire};
    tail_d = live ? head_q + {1'b0, off} + (TW+1)'(1) : tail_q + {{TW{1'b0}}, enq_fire};
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      head_q <= '0;
      tail_q <= '0;
      update_valid <= 1'b0;
      update_ras_idx <= '0;
      update_ras_cnt <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      update_valid <= live;
      if (live) begin
        update_ras_idx <= r_idx;
        update_ras_cnt <= r_cnt;
      end
    end
  always_ff @(posedge CLK)
    if (enq_fire) begin
      idx_mem_q[tail_q[TW-1:0]] <= enq_ras_idx;
      cnt_mem_q[tail_q[TW-1:0]] <= enq_ras_cnt;
    end
endmodule

// File: tb/tb_ras_checkpoint_q.sv
// tb_ras_checkpoint_q: scoreboard bench for the RAS checkpoint queue (DEPTH 16, 3-bit idx, RAS_ENTRIES 8).
module tb_ras_checkpoint_q;
  logic       CLK = 0, nRST = 0;
  logic       enq_valid = 0, commit_valid = 0, restore_valid = 0;
  logic [2:0] enq_ras_idx = 0;
  logic [3:0] enq_ras_cnt = 0;
  logic [3:0] restore_tag = 0;
  logic [1:0] restore_op = 0;
  logic       enq_ready, update_valid;
  logic [3:0] enq_tag, update_ras_cnt;
  logic [2:0] update_ras_idx;
  int checks = 0, errors = 0;
  int m_idx[16], m_cnt[16];
  int m_head = 0, m_tail = 0;
  int exp_q[$];

  ras_checkpoint_q dut (
    .CLK(CLK), .nRST(nRST),
    .enq_valid(enq_valid), .enq_ras_idx(enq_ras_idx), .enq_ras_cnt(enq_ras_cnt),
    .enq_ready(enq_ready), .enq_tag(enq_tag),
    .commit_valid(commit_valid),
    .restore_valid(restore_valid), .restore_tag(restore_tag), .restore_op(restore_op),
    .update_valid(update_valid), .update_ras_idx(update_ras_idx), .update_ras_cnt(update_ras_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int calc(int i, int c, int op);
    if (op & 2) begin
      i = (i + 7) % 8;
      c = (c > 0) ? c - 1 : 0;
    end
    if (op & 1) begin
      i = (i + 1) % 8;
      c = (c < 8) ? c + 1 : 8;
    end
    return i * 16 + c;
  endfunction

  task automatic tick();
    int e;
    @(posedge CLK);
    #1;
    chk("update_valid", int'(update_valid), int'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("update_idx", int'(update_ras_idx), e / 16);
      chk("update_cnt", int'(update_ras_cnt), e % 16);
    end
  endtask

  task automatic cycle(bit ev, int ei, int ec, bit cv, bit rv, int rt, int ro);
    int cnt, off, h;
    bit rdy, live;
    enq_valid = ev; enq_ras_idx = 3'(ei); enq_ras_cnt = 4'(ec);
    commit_valid = cv; restore_valid = rv; restore_tag = 4'(rt); restore_op = 2'(ro);
    #1;
    cnt = (m_tail - m_head) & 31;
    rdy = (cnt != 16) && !rv;
    chk("enq_ready", int'(enq_ready), int'(rdy));
    chk("enq_tag", int'(enq_tag), m_tail & 15);
    off = (rt - m_head) & 15;
    live = rv && (off < cnt);
    if (live) exp_q.push_back(calc(m_idx[rt], m_cnt[rt], ro));
    if (ev && rdy) begin
      m_idx[m_tail & 15] = ei;
      m_cnt[m_tail & 15] = ec;
    end
    h = m_head;
    m_head = (m_head + int'(cv && cnt != 0)) & 31;
    m_tail = live ? (h + off + 1) & 31 : (m_tail + int'(ev && rdy)) & 31;
    tick();
    enq_valid = 0; commit_valid = 0; restore_valid = 0;
  endtask

  task automatic do_reset();
    nRST = 0;
    exp_q.delete();
    m_head = 0;
    m_tail = 0;
    #1;
    chk("rst_update_valid", int'(update_valid), 0);
    chk("rst_update_idx", int'(update_ras_idx), 0);
    chk("rst_update_cnt", int'(update_ras_cnt), 0);
    chk("rst_enq_ready", int'(enq_ready), 1);
    chk("rst_enq_tag", int'(enq_tag), 0);
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  initial begin
    do_reset();
    // fill, drop when full, commit, wrap
    for (int i = 0; i < 16; i++) cycle(1, i & 7, i % 9, 0, 0, 0, 0);
    chk("full_not_ready", int'(enq_ready), 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    chk("ready_after_commit", int'(enq_ready), 1);
    chk("wrap_tag", int'(enq_tag), 0);
    cycle(1, 5, 5, 0, 0, 0, 0);
    // restore op none truncates tail
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, (i == 2) ? 3 : i, (i == 2) ? 2 : 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 2, 0);
    chk("none_idx", int'(update_ras_idx), 3);
    chk("none_cnt", int'(update_ras_cnt), 2);
    chk("tail_after_restore", int'(enq_tag), 3);
    cycle(1, 2, 2, 0, 0, 0, 0);
    // saturation and wrap of push/pop, back-to-back restores
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 7, 8, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 1);
    chk("push_sat_idx", int'(update_ras_idx), 0);
    chk("push_sat_cnt", int'(update_ras_cnt), 8);
    cycle(0, 0, 0, 0, 1, 0, 2);
    chk("pop_sat_idx", int'(update_ras_idx), 7);
    chk("pop_sat_cnt", int'(update_ras_cnt), 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 3);
    cycle(1, 4, 8, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 2, 3);
    // commit + restore of the only entry, then enq + restore
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, i, i, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 4, 1);
    cycle(0, 0, 0, 0, 1, 4, 0);
    cycle(1, 6, 6, 0, 0, 0, 0);
    cycle(1, 2, 2, 0, 1, 5, 2);
    cycle(0, 0, 0, 0, 1, 6, 0);
    // non-live tag and commit on empty
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, i, i, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 9, 1);
    chk("nonlive_tail", int'(enq_tag), 4);
    do_reset();
    cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, i & 7, i & 7, 0, 0, 0, 0);
    chk("empty_commit_full", int'(enq_ready), 0);
    // reset right after a restore
    do_reset();
    cycle(1, 3, 4, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 1);
    do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
